// File: rtl/mem_map_pkg.sv
// Address map and shared types for the CPU data-memory responder.
// Contents: screen/keyboard address constants, the FSM state enum, the region enum
// and a region-decode helper used by mem_responder.
package mem_map_pkg;

  localparam logic [15:0] SCR_BASE = 16'h4000;
  localparam logic [15:0] SCR_END  = 16'h5FFF;
  localparam logic [15:0] KBD_ADDR = 16'h6000;

  typedef enum logic [1:0] {StIdle, StRamRd, StKbdRd, StScrWait} mem_state_t;

  typedef enum logic [1:0] {RegRam, RegScr, RegKbd, RegBad} mem_region_t;

  // RAM occupies 0..ram_words-1; the gap up to SCR_BASE is unmapped when ram_words < 0x4000.
  function automatic mem_region_t decode_region(input logic [15:0] addr,
                                                input int unsigned ram_words);
    if ({16'h0000, addr} < ram_words) return RegRam;
    if (addr >= SCR_BASE && addr <= SCR_END) return RegScr;
    if (addr == KBD_ADDR) return RegKbd;
    return RegBad;
  endfunction

endpackage

// File: rtl/kbd_buffer.sv
// Keyboard code buffer between the keyboard front end and the responder.
// Build option MEM_RESPONDER_KBD_FIFO_EN: defined -> 4-entry FIFO, a push when full is
// dropped and reported on drop; undefined -> single register, push overwrites, pop clears.
// Ports: clk, reset_n (async active-low), push/din (capture), pop (consume oldest),
//        dout (oldest code), empty, full, drop (one-cycle overflow indication, comb).
module kbd_buffer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full,
  output logic        drop
);

`ifdef MEM_RESPONDER_KBD_FIFO_EN
  localparam int unsigned Depth = 4;

  logic [15:0] mem_q [Depth];
  logic [1:0]  rd_ptr_q, wr_ptr_q;
  logic [2:0]  count_q;
  logic        do_pop, do_push;

  // Pop is applied first, so a push into a full FIFO succeeds when a pop happens alongside.
  assign do_pop  = pop && (count_q != 3'd0);
  assign do_push = push && ((count_q != 3'(Depth)) || do_pop);

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 3'd0);
  assign full  = (count_q == 3'(Depth));
  assign drop  = push && !do_push;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end
`else
  logic [15:0] data_q;
  logic        valid_q;

  assign dout  = data_q;
  assign empty = !valid_q;
  assign full  = valid_q;
  assign drop  = 1'b0;

  // Push wins over pop: the pop clears first, then the new code lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else if (push) begin
      data_q  <= din;
      valid_q <= 1'b1;
    end else if (pop) begin
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mem_responder.sv
// CPU data-memory responder: decodes addrM into internal RAM, an external screen buffer
// (req/ack handshake with timeout) and a keyboard register, returning read data on inM.
// Build option MEM_RESPONDER_KBD_FIFO_EN selects the keyboard buffer depth (see kbd_buffer).
// Ports: clk, reset_n (async active-low); CPU side addrM/outM/wrtM/rdM in, inM/readyM/rvalid/
//        bad_addr out; screen side scr_addr/scr_wdata/scr_we/scr_req out, scr_ack/scr_rdata in;
//        keyboard side kbd_code/kbd_valid in.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS   = 16384,
  parameter int unsigned SCR_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addrM,
  input  logic [15:0] outM,
  input  logic        wrtM,
  input  logic        rdM,
  output logic [15:0] inM,
  output logic        readyM,
  output logic        rvalid,
  output logic        bad_addr,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_wdata,
  output logic        scr_we,
  output logic        scr_req,
  input  logic        scr_ack,
  input  logic [15:0] scr_rdata,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  mem_state_t  state_q;
  mem_region_t region;
  logic [AW-1:0] addr_q;
  logic          rd_bad_q;
  logic [7:0]    cnt_q;
  logic          accept;
  logic          kbd_pop, kbd_empty, kbd_full, kbd_drop;
  logic [15:0]   kbd_dout;
  logic [15:0]   ram_q [RAM_WORDS];

  assign region  = decode_region(addrM, RAM_WORDS);
  assign readyM  = (state_q == StIdle);
  assign accept  = readyM && (wrtM || rdM);
  assign kbd_pop = (state_q == StKbdRd);

  kbd_buffer u_kbd_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (kbd_valid),
    .din     (kbd_code),
    .pop     (kbd_pop),
    .dout    (kbd_dout),
    .empty   (kbd_empty),
    .full    (kbd_full),
    .drop    (kbd_drop)
  );

  // RAM writes complete in the accept cycle; contents are not reset.
  always_ff @(posedge clk) begin
    if (accept && wrtM && region == RegRam) ram_q[addrM[AW-1:0]] <= outM;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rd_bad_q  <= 1'b0;
      cnt_q     <= 8'd0;
      inM       <= 16'h0000;
      rvalid    <= 1'b0;
      bad_addr  <= 1'b0;
      scr_addr  <= 13'h0000;
      scr_wdata <= 16'h0000;
      scr_we    <= 1'b0;
      scr_req   <= 1'b0;
    end else begin
      rvalid   <= 1'b0;
      bad_addr <= kbd_drop;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            // wrtM takes priority: with both set the read is simply dropped.
            unique case (region)
              RegRam: begin
                if (!wrtM) begin
                  state_q  <= StRamRd;
                  addr_q   <= addrM[AW-1:0];
                  rd_bad_q <= 1'b0;
                end
              end
              RegScr: begin
                state_q   <= StScrWait;
                scr_req   <= 1'b1;
                scr_we    <= wrtM;
                scr_addr  <= addrM[12:0];
                scr_wdata <= outM;
                cnt_q     <= 8'd0;
              end
              RegKbd: begin
                if (wrtM) bad_addr <= 1'b1;
                else      state_q  <= StKbdRd;
              end
              RegBad: begin
                if (wrtM) begin
                  bad_addr <= 1'b1;
                end else begin
                  state_q  <= StRamRd;
                  rd_bad_q <= 1'b1;
                end
              end
            endcase
          end
        end
        StRamRd: begin
          inM     <= rd_bad_q ? 16'h0000 : ram_q[addr_q];
          rvalid  <= 1'b1;
          state_q <= StIdle;
          if (rd_bad_q) bad_addr <= 1'b1;
        end
        StKbdRd: begin
          inM     <= kbd_empty ? 16'h0000 : kbd_dout;
          rvalid  <= 1'b1;
          state_q <= StIdle;
        end
        StScrWait: begin
          if (scr_ack) begin
            if (!scr_we) begin
              inM    <= scr_rdata;
              rvalid <= 1'b1;
            end
            scr_req <= 1'b0;
            scr_we  <= 1'b0;
            cnt_q   <= 8'd0;
            state_q <= StIdle;
          end else if (cnt_q == 8'(SCR_TIMEOUT - 1)) begin
            // Last waiting cycle without ack: scr_req has been high SCR_TIMEOUT cycles.
            if (!scr_we) begin
              inM    <= 16'h0000;
              rvalid <= 1'b1;
            end
            bad_addr <= 1'b1;
            scr_req  <= 1'b0;
            scr_we   <= 1'b0;
            cnt_q    <= 8'd0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] addrM = 16'h0000;
  logic [15:0] outM = 16'h0000;
  logic        wrtM = 1'b0;
  logic        rdM = 1'b0;
  logic [15:0] inM;
  logic        readyM, rvalid, bad_addr;
  logic [12:0] scr_addr;
  logic [15:0] scr_wdata;
  logic        scr_we, scr_req;
  logic        scr_ack = 1'b0;
  logic [15:0] scr_rdata = 16'h0000;
  logic [15:0] kbd_code = 16'h0000;
  logic        kbd_valid = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addrM     (addrM),
    .outM      (outM),
    .wrtM      (wrtM),
    .rdM       (rdM),
    .inM       (inM),
    .readyM    (readyM),
    .rvalid    (rvalid),
    .bad_addr  (bad_addr),
    .scr_addr  (scr_addr),
    .scr_wdata (scr_wdata),
    .scr_we    (scr_we),
    .scr_req   (scr_req),
    .scr_ack   (scr_ack),
    .scr_rdata (scr_rdata),
    .kbd_code  (kbd_code),
    .kbd_valid (kbd_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [15:0] d, output logic rv,
                         output logic bd);
    addrM = a;
    rdM = 1'b1;
    tick();
    rdM = 1'b0;
    tick();
    d = inM;
    rv = rvalid;
    bd = bad_addr;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, output logic bd,
                          output logic rdy);
    addrM = a;
    outM = d;
    wrtM = 1'b1;
    tick();
    wrtM = 1'b0;
    bd = bad_addr;
    rdy = readyM;
  endtask

  task automatic kbd_push(input logic [15:0] code);
    kbd_code = code;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
  endtask

  // Counts cycles with scr_req high after an accepted screen access; raises scr_ack once
  // ack_after request cycles have been seen (0 = never ack).
  task automatic scr_wait(input int ack_after, output int req_cycles, output logic done);
    req_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (scr_req) req_cycles++;
      if (ack_after != 0 && req_cycles == ack_after) scr_ack = 1'b1;
      tick();
      if (!scr_req) done = 1'b1;
    end
    scr_ack = 1'b0;
  endtask

  typedef struct {
    logic        wrt;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_inm;
    logic        exp_bad;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    logic [15:0] d;
    logic        rv, bd, rdy, done;
    int          req_cycles;

    vecs[0]  = '{1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h0011, 16'hA5A5, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, 16'hA5A5, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'h7000, 16'h0000, 16'h0000, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 16'h8000, 16'h3333, 16'h0000, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 16'h0010, 16'h5555, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'h5555, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 16'h3FFF, 16'hCAFE, 16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'h3FFF, 16'h0000, 16'hCAFE, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'h6001, 16'h0000, 16'h0000, 1'b1};

    // Reset state.
    #1;
    chk("rst_readyM", readyM, 1);
    chk("rst_inM", inM, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bad", bad_addr, 0);
    chk("rst_scr_req", scr_req, 0);
    chk("rst_scr_we", scr_we, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // RAM / unmapped vectors.
    for (int i = 0; i < NV; i++) begin
      addrM = vecs[i].addr;
      outM = vecs[i].wdata;
      wrtM = vecs[i].wrt;
      rdM = vecs[i].rd;
      tick();
      wrtM = 1'b0;
      rdM = 1'b0;
      if (vecs[i].wrt) begin
        chk($sformatf("v%0d_wr_ready", i), readyM, 1);
        chk($sformatf("v%0d_wr_rvalid", i), rvalid, 0);
        chk($sformatf("v%0d_wr_bad", i), bad_addr, vecs[i].exp_bad);
        tick();
        chk($sformatf("v%0d_wr_rvalid_late", i), rvalid, 0);
      end else begin
        chk($sformatf("v%0d_rd_stall", i), readyM, 0);
        chk($sformatf("v%0d_rd_early_rvalid", i), rvalid, 0);
        tick();
        chk($sformatf("v%0d_rd_rvalid", i), rvalid, 1);
        chk($sformatf("v%0d_rd_inM", i), inM, vecs[i].exp_inm);
        chk($sformatf("v%0d_rd_bad", i), bad_addr, vecs[i].exp_bad);
        chk($sformatf("v%0d_rd_ready", i), readyM, 1);
      end
    end

    // Keyboard: empty read, two codes, a dropped write, two reads.
    do_read(16'h6000, d, rv, bd);
    chk("kbd_empty_inM", d, 0);
    chk("kbd_empty_rvalid", rv, 1);
    kbd_push(16'h0041);
    kbd_push(16'h0042);
    do_write(16'h6000, 16'h0099, bd, rdy);
    chk("kbd_wr_bad", bd, 1);
    chk("kbd_wr_ready", rdy, 1);
    tick();
    do_read(16'h6000, d, rv, bd);
    chk("kbd_rd1_rvalid", rv, 1);
    chk("kbd_rd1_bad", bd, 0);
`ifdef MEM_RESPONDER_KBD_FIFO_EN
    chk("kbd_rd1_inM", d, 16'h0041);
    do_read(16'h6000, d, rv, bd);
    chk("kbd_rd2_inM", d, 16'h0042);
`else
    chk("kbd_rd1_inM", d, 16'h0042);
    do_read(16'h6000, d, rv, bd);
    chk("kbd_rd2_inM", d, 16'h0000);
`endif
    chk("kbd_rd2_rvalid", rv, 1);

    // Screen read acked after 3 request cycles.
    scr_rdata = 16'hBEEF;
    addrM = 16'h4005;
    rdM = 1'b1;
    tick();
    rdM = 1'b0;
    chk("scr_rd_req", scr_req, 1);
    chk("scr_rd_addr", scr_addr, 13'h0005);
    chk("scr_rd_we", scr_we, 0);
    chk("scr_rd_stall", readyM, 0);
    scr_wait(3, req_cycles, done);
    chk("scr_rd_done", done, 1);
    chk("scr_rd_req_cycles", req_cycles, 3);
    chk("scr_rd_rvalid", rvalid, 1);
    chk("scr_rd_inM", inM, 16'hBEEF);
    chk("scr_rd_ready", readyM, 1);
    chk("scr_rd_bad", bad_addr, 0);

    // Screen write with no ack: times out.
    addrM = 16'h4100;
    outM = 16'h1111;
    wrtM = 1'b1;
    tick();
    wrtM = 1'b0;
    chk("scr_wr_we", scr_we, 1);
    chk("scr_wr_wdata", scr_wdata, 16'h1111);
    chk("scr_wr_addr", scr_addr, 13'h0100);
    scr_wait(0, req_cycles, done);
    chk("scr_wr_done", done, 1);
    chk("scr_wr_req_cycles", req_cycles, 15);
    chk("scr_wr_bad", bad_addr, 1);
    chk("scr_wr_rvalid", rvalid, 0);
    chk("scr_wr_ready", readyM, 1);
    tick();
    chk("scr_wr_bad_pulse", bad_addr, 0);

    // Screen read timeout returns 0 with rvalid and bad_addr.
    addrM = 16'h5FFF;
    rdM = 1'b1;
    tick();
    rdM = 1'b0;
    chk("scr_to_addr", scr_addr, 13'h1FFF);
    scr_wait(0, req_cycles, done);
    chk("scr_to_req_cycles", req_cycles, 15);
    chk("scr_to_rvalid", rvalid, 1);
    chk("scr_to_inM", inM, 0);
    chk("scr_to_bad", bad_addr, 1);

    // Ack while idle is ignored.
    scr_ack = 1'b1;
    tick();
    scr_ack = 1'b0;
    chk("idle_ack_rvalid", rvalid, 0);
    chk("idle_ack_req", scr_req, 0);
    chk("idle_ack_ready", readyM, 1);

    // Reset in the middle of a screen wait.
    do_read(16'h0010, d, rv, bd);
    chk("pre_rst_inM", d, 16'h5555);
    addrM = 16'h4000;
    rdM = 1'b1;
    tick();
    rdM = 1'b0;
    tick();
    tick();
    chk("mid_wait_req", scr_req, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", scr_req, 0);
    chk("mid_rst_ready", readyM, 1);
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_bad", bad_addr, 0);
    chk("mid_rst_inM", inM, 0);
    chk("mid_rst_we", scr_we, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    do_write(16'h0020, 16'h7777, bd, rdy);
    do_read(16'h0020, d, rv, bd);
    chk("post_rst_rvalid", rv, 1);
    chk("post_rst_inM", d, 16'h7777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
